// File: rtl/alu_rf_sequencer.sv
// Command sequencer that drives a register bank and ALU: ALU ops walk READ/EXEC/WB,
// load-immediate goes straight to WB. Commands are fully serialized.
module alu_rf_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [3:0]       cmd_mode,
    input  logic [4:0]       cmd_sr1,
    input  logic [4:0]       cmd_sr2,
    input  logic [4:0]       cmd_dr,
    input  logic [31:0]      cmd_imm,
    output logic [4:0]       sr1,
    output logic [4:0]       sr2,
    output logic [4:0]       dr,
    output logic             write,
    output logic             sel,
    output logic [31:0]      wrData,
    output logic             alu_en,
    output logic [3:0]       alu_mode,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWb
    } state_e;

    state_e             state_q, state_d;
    logic               armed_q;
    logic               op_q;
    logic [3:0]         mode_q;
    logic [4:0]         sr1_q, sr2_q, dr_q;
    logic [31:0]        wrdata_q;
    logic [CNT_W-1:0]   count_q;
    logic               accept;

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        write     = 1'b0;
        alu_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy      = 1'b0;
                // armed_q keeps ready low until the first edge after reset
                cmd_ready = armed_q;
                if (accept) begin
                    state_d = cmd_op ? StWb : StRead;
                end
            end
            StRead: state_d = StExec;
            StExec: begin
                state_d = StWb;
                alu_en  = 1'b1;
            end
            StWb: begin
                state_d = StIdle;
                write   = 1'b1;
                alu_en  = !op_q;
            end
            default: state_d = StIdle;
        endcase
    end

    assign done     = write;
    assign sel      = !(write && !op_q);
    assign alu_mode = alu_en ? mode_q : 4'd0;
    assign sr1      = sr1_q;
    assign sr2      = sr2_q;
    assign dr       = dr_q;
    assign wrData   = wrdata_q;
    assign op_count = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            armed_q  <= 1'b0;
            op_q     <= 1'b0;
            mode_q   <= 4'd0;
            sr1_q    <= 5'd0;
            sr2_q    <= 5'd0;
            dr_q     <= 5'd0;
            wrdata_q <= 32'd0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            if (accept) begin
                op_q   <= cmd_op;
                mode_q <= cmd_mode;
                sr1_q  <= cmd_sr1;
                sr2_q  <= cmd_sr2;
                dr_q   <= cmd_dr;
                // wrData only changes for loads so it holds its value through ALU ops
                if (cmd_op) begin
                    wrdata_q <= cmd_imm;
                end
            end
            if (write) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Bench for alu_rf_sequencer: transaction-level model plus a register bank and ALU,
// directed scenarios followed by randomized commands and occasional async resets.
module tb_alu_rf_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_op = 1'b0;
    logic [3:0]  cmd_mode = 4'd0;
    logic [4:0]  cmd_sr1 = 5'd0, cmd_sr2 = 5'd0, cmd_dr = 5'd0;
    logic [31:0] cmd_imm = 32'd0;

    logic        cmd_ready, write, sel, alu_en, done, busy;
    logic [4:0]  sr1, sr2, dr;
    logic [31:0] wrData;
    logic [3:0]  alu_mode;
    logic [15:0] op_count;

    logic        s_cmd_ready, s_write, s_sel, s_alu_en, s_done, s_busy;
    logic [4:0]  s_sr1, s_sr2, s_dr;
    logic [31:0] s_wrData;
    logic [3:0]  s_alu_mode;
    logic [2:0]  s_op_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_rf_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_sr1(cmd_sr1), .cmd_sr2(cmd_sr2),
        .cmd_dr(cmd_dr), .cmd_imm(cmd_imm), .sr1(sr1), .sr2(sr2), .dr(dr),
        .write(write), .sel(sel), .wrData(wrData), .alu_en(alu_en),
        .alu_mode(alu_mode), .done(done), .busy(busy), .op_count(op_count)
    );

    // Narrow counter instance so counter wrap is exercised within a short run
    alu_rf_sequencer #(.CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_sr1(cmd_sr1), .cmd_sr2(cmd_sr2),
        .cmd_dr(cmd_dr), .cmd_imm(cmd_imm), .sr1(s_sr1), .sr2(s_sr2), .dr(s_dr),
        .write(s_write), .sel(s_sel), .wrData(s_wrData), .alu_en(s_alu_en),
        .alu_mode(s_alu_mode), .done(s_done), .busy(s_busy), .op_count(s_op_count)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] m, input logic [31:0] a,
                                            input logic [31:0] b);
        case (m[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register bank driven by the DUT
    logic [31:0] rf [32] = '{default: 32'd0};
    logic [31:0] alu_res;
    assign alu_res = alu_fn(alu_mode, rf[sr1], rf[sr2]);
    always @(posedge clk) if (write) rf[dr] <= sel ? wrData : alu_res;

    // Transaction-level model: a command occupies m_n cycles after its accept edge
    logic [31:0] model_rf [32] = '{default: 32'd0};
    int          m_step = 0, m_n = 0, cyc = 0, m_acc_cyc = 0;
    bit          m_armed = 0, m_acc = 0, m_op = 0;
    logic [3:0]  m_mode = 4'd0;
    logic [4:0]  m_sr1 = 5'd0, m_sr2 = 5'd0, m_dr = 5'd0;
    logic [31:0] m_imm = 32'd0, m_wr = 32'd0;
    int unsigned m_count = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_armed = 0; m_step = 0; m_n = 0; m_count = 0; m_wr = 32'd0; m_acc = 0;
        end else begin
            cyc++;
            m_acc = 0;
            if (m_step != 0) begin
                if (m_step == m_n) begin
                    m_count++;
                    model_rf[m_dr] = m_op ? m_imm
                                          : alu_fn(m_mode, model_rf[m_sr1], model_rf[m_sr2]);
                    m_step = 0;
                end else begin
                    m_step++;
                end
            end else if (m_armed && cmd_valid) begin
                m_op = cmd_op; m_mode = cmd_mode; m_sr1 = cmd_sr1; m_sr2 = cmd_sr2;
                m_dr = cmd_dr; m_imm = cmd_imm;
                m_step = 1;
                m_n = cmd_op ? 1 : 3;
                if (cmd_op) m_wr = cmd_imm;
                m_acc = 1;
                m_acc_cyc = cyc;
            end
            m_armed = 1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_write", write, 0);
            chk("rst_done", done, 0);
            chk("rst_alu_en", alu_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_sel", sel, 1);
            chk("rst_sr1", sr1, 0);
            chk("rst_sr2", sr2, 0);
            chk("rst_dr", dr, 0);
            chk("rst_wrData", wrData, 0);
            chk("rst_alu_mode", alu_mode, 0);
            chk("rst_op_count", op_count, 0);
        end else begin
            bit e_busy, e_wb, e_alu;
            e_busy = (m_step != 0);
            e_wb   = e_busy && (m_step == m_n);
            e_alu  = e_busy && !m_op && (m_step >= 2);
            chk("cmd_ready", cmd_ready, !e_busy && m_armed);
            chk("busy", busy, e_busy);
            chk("write", write, e_wb);
            chk("done", done, e_wb);
            chk("alu_en", alu_en, e_alu);
            chk("sel", sel, !(e_wb && !m_op));
            chk("wrData", wrData, m_wr);
            chk("op_count", op_count, m_count % 65536);
            chk("small_op_count", s_op_count, m_count % 8);
            chk("small_write", s_write, e_wb);
            chk("small_busy", s_busy, e_busy);
            chk("small_cmd_ready", s_cmd_ready, !e_busy && m_armed);
            if (e_alu) chk("alu_mode", alu_mode, m_mode);
            if (e_busy && !m_op) begin
                chk("sr1", sr1, m_sr1);
                chk("sr2", sr2, m_sr2);
            end
            if (e_wb) chk("dr", dr, m_dr);
        end
    end

    task automatic send(input bit op, input logic [3:0] mode, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] d, input logic [31:0] imm,
                        output int acc_cyc);
        cmd_op = op; cmd_mode = mode; cmd_sr1 = s1; cmd_sr2 = s2; cmd_dr = d; cmd_imm = imm;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (m_acc) break;
        end
        chk("accept_seen", m_acc, 1);
        acc_cyc = m_acc_cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1, a2, a3;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1 chk("ready_low_after_reset", cmd_ready, 0);
        step_cycle();
        chk("ready_first_edge", cmd_ready, 1);

        // Two loads, two cycles apart
        send(1'b1, 4'd0, 5'd0, 5'd0, 5'd1, 32'd370, a0);
        send(1'b1, 4'd0, 5'd0, 5'd0, 5'd2, 32'd4, a1);
        chk("load_spacing", a1 - a0, 2);
        step_cycle();
        chk("r1", rf[1], 370);
        chk("r2", rf[2], 4);
        chk("count_after_loads", op_count, 2);

        // ALU add; mode/dr changed during READ must not matter
        send(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 32'd0, a2);
        cmd_mode = 4'd1; cmd_dr = 5'd5;
        chk("read_no_write", write, 0);
        step_cycle();
        chk("exec_no_write", write, 0);
        chk("exec_alu_en", alu_en, 1);
        step_cycle();
        chk("wb_write", write, 1);
        chk("wb_sel", sel, 0);
        chk("wb_dr", dr, 3);
        chk("wb_done", done, 1);
        step_cycle();
        chk("post_wb_done", done, 0);
        chk("r3", rf[3], 374);
        chk("r5_untouched", rf[5], 0);
        chk("count_after_alu", op_count, 3);

        // Second command held valid during an ALU op
        send(1'b0, 4'd1, 5'd3, 5'd1, 5'd4, 32'd0, a2);
        send(1'b1, 4'd0, 5'd0, 5'd0, 5'd6, 32'h0000abcd, a3);
        chk("alu_spacing", a3 - a2, 4);
        step_cycle();
        chk("r4", rf[4], 4);
        chk("r6", rf[6], 32'h0000abcd);

        // Abort an ALU op during EXEC
        send(1'b0, 4'd2, 5'd1, 5'd2, 5'd3, 32'd0, a2);
        step_cycle();
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_write", write, 0);
        chk("abort_count", op_count, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        step_cycle();
        step_cycle();
        chk("r3_after_abort", rf[3], 374);
        chk("count_after_abort", op_count, 0);

        // Eight loads wrap the 3-bit counter
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 4'd0, 5'd0, 5'd0, 5'(8 + i), 32'(100 + i), a0);
            step_cycle();
        end
        chk("small_wrap", s_op_count, 0);
        chk("count_eight", op_count, 8);

        // Randomized traffic with field churn and occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 1'($urandom_range(0, 1));
            cmd_mode  = 4'($urandom_range(0, 15));
            cmd_sr1   = 5'($urandom_range(0, 7));
            cmd_sr2   = 5'($urandom_range(0, 7));
            cmd_dr    = 5'($urandom_range(0, 7));
            cmd_imm   = $urandom;
            #1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) reset = 1'b1;
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        cmd_valid = 1'b0;
        repeat (6) step_cycle();
        for (int r = 0; r < 32; r++) chk($sformatf("rf[%0d]", r), rf[r], model_rf[r]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
